// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debounce, and a
// press classifier that emits press/release edges plus short/long press pulses.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CNT   = 32'd500000,
  parameter int unsigned LONG_CNT       = 32'd25000000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk_25m,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_short,
  output logic key_long
);

  localparam logic        RELEASED_RAW = KEY_ACTIVE_LOW;
  localparam logic [31:0] DEB_LAST     = 32'(DEBOUNCE_CNT - 32'd1);
  localparam logic [31:0] LONG_LAST    = 32'(LONG_CNT - 32'd1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  logic        sync1_q, sync2_q;
  logic        key_sync;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        key_state_q, key_state_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;

  // Metastability guard; reset parks the chain at the released level
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Stable-time window: any disagreement run shorter than DEBOUNCE_CNT restarts
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    if (key_sync == key_state_q) begin
      deb_cnt_d = 32'd0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d   = 32'd0;
      key_state_d = ~key_state_q;
      press_d     = ~key_state_q;
      release_d   = key_state_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 32'd1;
    end
  end

  // Press classifier; a release landing on the threshold cycle wins over key_long
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d = PRESSED;
          hold_d  = 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        if (release_d) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (hold_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else if (key_state_q) begin
          hold_d = hold_q + 32'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      LONG_HELD: begin
        if (release_d) begin
          state_d = IDLE;
        end else begin
          state_d = LONG_HELD;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 32'd0;
      end
    endcase
  end

  // State and registered output pulses
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      deb_cnt_q   <= 32'd0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= 32'd0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_short   = short_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CNT=8, LONG_CNT=32, active-low key).
// Expected pulses/levels are queued at drive time and checked every cycle.
module tb_key_debounce;

  logic clk_25m = 1'b0;
  logic rst;
  logic key_in;
  logic key_state, key_press, key_release, key_short, key_long;

  key_debounce #(
    .DEBOUNCE_CNT  (32'd8),
    .LONG_CNT      (32'd32),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_25m    (clk_25m),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_short  (key_short),
    .key_long   (key_long)
  );

  always #20 clk_25m = ~clk_25m;

  int cyc = 0;
  always @(posedge clk_25m) cyc <= cyc + 1;

  // pulses = {press, release, short, long}; state = key_state from that cycle on
  typedef struct {
    int         at;
    logic [3:0] pulses;
    logic       state;
  } exp_t;

  exp_t sb_q[$];
  logic exp_state = 1'b0;
  int   chk_cnt   = 0;
  int   pass_cnt  = 0;

  localparam logic [3:0] P_PRESS = 4'b1000;
  localparam logic [3:0] P_REL   = 4'b0100;
  localparam logic [3:0] P_SHORT = 4'b0010;
  localparam logic [3:0] P_LONG  = 4'b0001;

  task automatic expect_at(input int at, input logic [3:0] pulses, input logic state);
    exp_t e;
    e.at     = at;
    e.pulses = pulses;
    e.state  = state;
    sb_q.push_back(e);
  endtask

  task automatic check_cycle();
    logic [3:0] exp_p;
    logic [3:0] obs_p;
    exp_p = 4'b0000;
    if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
      exp_p     = sb_q[0].pulses;
      exp_state = sb_q[0].state;
      void'(sb_q.pop_front());
    end
    obs_p = {key_press, key_release, key_short, key_long};
    chk_cnt++;
    assert (obs_p === exp_p) pass_cnt++;
    else $error("FAIL pulses cyc=%0d: observed %b expected %b", cyc, obs_p, exp_p);
    chk_cnt++;
    assert (key_state === exp_state) pass_cnt++;
    else $error("FAIL key_state cyc=%0d: observed %b expected %b", cyc, key_state, exp_state);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25m);
      check_cycle();
    end
  endtask

  initial begin
    int c;
    rst    = 1'b1;
    key_in = 1'b1;
    step(3);
    rst = 1'b0;
    step(5);

    // clean short press: held 20 cycles after key_press
    c = cyc;
    key_in = 1'b0;
    expect_at(c + 10, P_PRESS, 1'b1);
    step(30);
    key_in = 1'b1;
    expect_at(c + 40, P_REL | P_SHORT, 1'b0);
    step(15);

    // bounce every 3 cycles, settle pressed, then hold into a long press
    c = cyc;
    for (int t = 0; t < 7; t++) begin
      key_in = ~key_in;
      step(3);
    end
    expect_at(c + 28, P_PRESS, 1'b1);
    expect_at(c + 60, P_LONG, 1'b1);
    step(49);
    key_in = 1'b1;
    expect_at(c + 80, P_REL, 1'b0);
    step(15);

    // reset mid-press with the key still held
    c = cyc;
    key_in = 1'b0;
    expect_at(c + 10, P_PRESS, 1'b1);
    step(15);
    rst = 1'b1;
    expect_at(c + 16, 4'b0000, 1'b0);
    step(1);
    rst = 1'b0;
    expect_at(c + 26, P_PRESS, 1'b1);
    step(14);
    key_in = 1'b1;
    expect_at(c + 40, P_REL | P_SHORT, 1'b0);
    step(15);

    // 7-cycle glitch must be swallowed
    key_in = 1'b0;
    step(7);
    key_in = 1'b1;
    step(20);

    // release lands on the threshold cycle: short wins, no long
    c = cyc;
    key_in = 1'b0;
    expect_at(c + 10, P_PRESS, 1'b1);
    step(32);
    key_in = 1'b1;
    expect_at(c + 42, P_REL | P_SHORT, 1'b0);
    step(20);

    // release one cycle later: long fires, then a plain release
    c = cyc;
    key_in = 1'b0;
    expect_at(c + 10, P_PRESS, 1'b1);
    expect_at(c + 42, P_LONG, 1'b1);
    step(33);
    key_in = 1'b1;
    expect_at(c + 43, P_REL, 1'b0);
    step(25);

    chk_cnt++;
    assert (sb_q.size() == 0) pass_cnt++;
    else $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 500000, sets the stable-time window in clk_25m cycles (20 ms); legal range 2..2^32-1.
REQ-002 Parameter LONG_CNT, default 25000000, sets the long-press threshold in clk_25m cycles (1 s); legal range 2..2^32-1; must exceed DEBOUNCE_CNT.
REQ-003 Parameter KEY_ACTIVE_LOW, default 1; 1 means key_in=0 is pressed, 0 means key_in=1 is pressed.
REQ-004 Port clk_25m  input  1  25 MHz system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port key_in  input  1  raw, asynchronous, bouncing push-button level.
REQ-007 Port key_state  output  1  debounced level; 1 = pressed.
REQ-008 Port key_press  output  1  one-cycle pulse on the debounced press edge.
REQ-009 Port key_release  output  1  one-cycle pulse on the debounced release edge.
REQ-010 Port key_short  output  1  one-cycle pulse on release when the press did not reach LONG_CNT.
REQ-011 Port key_long  output  1  one-cycle pulse when the press reaches LONG_CNT; at most once per press.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; it SHALL then be normalized to pressed=1 per KEY_ACTIVE_LOW, giving key_sync.
REQ-013 A 32-bit debounce counter SHALL clear to 0 in any cycle where key_sync equals key_state.
REQ-014 When key_sync differs from key_state, the counter SHALL increment; when it equals DEBOUNCE_CNT-1 while still differing, key_state SHALL toggle and the counter SHALL clear on that edge.
REQ-015 Any glitch shorter than DEBOUNCE_CNT cycles at key_sync SHALL restart the window and SHALL NOT change key_state.
REQ-016 Latency: a clean key_in edge SHALL appear on key_state exactly 2+DEBOUNCE_CNT cycles later.
REQ-017 key_press/key_release SHALL be registered and asserted in the same cycle key_state first shows the new level, for exactly one cycle.
REQ-018 FSM states: IDLE, PRESSED, LONG_HELD; the reset state is IDLE.
REQ-019 IDLE->PRESSED on the debounced press edge; the 32-bit hold counter SHALL clear to 0.
REQ-020 In PRESSED, the hold counter SHALL increment each cycle key_state=1; when it reaches LONG_CNT-1, key_long SHALL pulse on the next cycle and the FSM SHALL move to LONG_HELD.
REQ-021 PRESSED->IDLE on the debounced release edge; key_short SHALL pulse in the same cycle as key_release.
REQ-022 LONG_HELD->IDLE on the debounced release edge; key_release SHALL pulse and key_short SHALL NOT pulse.
REQ-023 The hold counter SHALL freeze in LONG_HELD; it SHALL never wrap.
REQ-024 If release and hold-threshold coincide in the same cycle, release SHALL take priority: key_short and key_release pulse, and key_long does not.
REQ-025 key_press and key_release SHALL never be asserted in the same cycle; at most one of key_short/key_long SHALL be asserted per press.

Reset
REQ-026 While rst=1, synchronizer flops SHALL load the released level, all counters 0, FSM IDLE, all outputs 0.
REQ-027 Reset mid-press SHALL abort without a key_release or key_short pulse.
REQ-028 If the key is still held after reset deasserts, a fresh key_press SHALL occur 2+DEBOUNCE_CNT cycles after rst falls.

Verification (DEBOUNCE_CNT=8, LONG_CNT=32, KEY_ACTIVE_LOW=1)
REQ-029 Clean press: key_in 1->0 at cycle 0 and held -> key_state=1 and key_press pulses at cycle 10 only.
REQ-030 Bounce: key_in toggles every 3 cycles for 20 cycles, then holds 0 -> exactly one key_press, 10 cycles after the last toggle.
REQ-031 Short press: held 20 cycles after key_press, then clean release -> key_release and key_short in the same cycle, 10 cycles after the release edge; no key_long.
REQ-032 Long press: held -> key_long pulses once, 32 cycles after key_press; later release -> key_release without key_short.
REQ-033 Reset mid-press: rst high 1 cycle in PRESSED with key held -> outputs 0, no release/short pulse; key_press again 10 cycles after rst falls.
REQ-034 Glitch: 0-pulse of 7 cycles on key_in -> key_state stays 0; no pulses on any output.
